// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, a registered output slot and a one-entry skid for decode stalls.
// Output appears one cycle after imem_valid; on stall the slot holds; branch_taken flushes and redirects.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               decode_stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [4:0]         opcode
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [ADDR_W-1:0]  req_pc, req_pc_n;
  logic [ADDR_W-1:0]  instr_pc_n;
  logic [ADDR_W-1:0]  skid_pc, skid_pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic               instr_valid_n;
  logic               discard, discard_n;
  logic               consume;

  assign consume   = instr_valid && !decode_stall;
  assign imem_req  = (state == S_FETCH) && !branch_taken && !rst;
  assign imem_addr = pc;
  // A bubble must decode as all-zero control, so the opcode is masked rather than the slot.
  assign opcode    = instr_valid ? instr[INSTR_W-1 -: 5] : 5'b00000;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    req_pc_n      = req_pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid && !consume;
    skid_instr_n  = skid_instr;
    skid_pc_n     = skid_pc;
    discard_n     = discard;

    if (branch_taken) begin
      pc_n          = branch_target;
      instr_valid_n = 1'b0;
      skid_instr_n  = '0;
      skid_pc_n     = '0;
      // An in-flight read with no response yet must be swallowed when it arrives.
      if (state == S_WAIT && !imem_valid) begin
        discard_n = 1'b1;
        state_n   = S_WAIT;
      end else begin
        discard_n = 1'b0;
        state_n   = S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          req_pc_n = pc;
          pc_n     = pc + ADDR_W'(PC_STEP);
          state_n  = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            state_n = S_FETCH;
            if (discard) begin
              discard_n = 1'b0;
            end else if (!instr_valid || consume) begin
              instr_n       = imem_rdata;
              instr_pc_n    = req_pc;
              instr_valid_n = 1'b1;
            end else begin
              skid_instr_n = imem_rdata;
              skid_pc_n    = req_pc;
              state_n      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            instr_n       = skid_instr;
            instr_pc_n    = skid_pc;
            instr_valid_n = 1'b1;
            state_n       = S_FETCH;
          end
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      req_pc      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_pc      <= req_pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      skid_instr  <= skid_instr_n;
      skid_pc     <= skid_pc_n;
      discard     <= discard_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder + program-order scoreboard; a monitor pops on every accepted instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        decode_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [4:0]  opcode;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .decode_stall(decode_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int acc_cnt = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] exp_q[$];
  logic [31:0] fetch_exp = '0;
  logic        pending = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0800_0000;
    if (a == 32'h4) return 32'h1800_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Expected accept order after a reset or redirect is simply sequential from the new start address.
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic step(input logic r, input logic b, input logic [31:0] t, input logic s);
    @(negedge clk);
    rst = r; branch_taken = b; branch_target = t; decode_stall = s;
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (pending) begin
      if (r && !stray) begin
        stray = 1'b1;
        cnt   = 0;
      end else if (cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = stray ? 32'hDEAD_BEEF : mem_word(pend_addr);
        pending    = 1'b0;
        stray      = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (r) begin
      refill(32'h0);
      fetch_exp = 32'h0;
    end else if (b) begin
      refill(t);
      fetch_exp = t;
    end
    #1;
    if (r || b) begin
      check("no_req_on_rst_or_branch", 32'(imem_req), 32'h0);
    end else if (imem_req) begin
      check("single_outstanding", 32'(pending), 32'h0);
      check("imem_addr", imem_addr, fetch_exp);
      fetch_exp = fetch_exp + 32'h4;
      req_cnt++;
      pending   = 1'b1;
      stray     = 1'b0;
      pend_addr = imem_addr;
      cnt       = $urandom_range(lat_max - 1, lat_min - 1);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_no_req", 32'(imem_req), 32'h0);
    req_cnt = 0;
    acc_cnt = 0;
  endtask

  // Monitor: compares every accepted instruction against the scoreboard queue.
  logic        prev_flush = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] w;
    forever begin
      @(negedge clk); #2;
      if (prev_flush) check("flush_clears_valid", 32'(instr_valid), 32'h0);
      if (prev_hold) begin
        check("stall_hold_valid", 32'(instr_valid), 32'h1);
        check("stall_hold_pc", instr_pc, prev_pc);
        check("stall_hold_instr", instr, prev_instr);
      end
      if (!rst && instr_valid === 1'b0) check("bubble_opcode", 32'(opcode), 32'h0);
      if (!rst && !branch_taken && instr_valid === 1'b1 && !decode_stall) begin
        exp_q.push_back(exp_q[$] + 32'h4);
        exp_pc = exp_q.pop_front();
        w = mem_word(exp_pc);
        check("out_pc", instr_pc, exp_pc);
        check("out_instr", instr, w);
        check("out_opcode", 32'(opcode), 32'(w[31:27]));
        acc_cnt++;
      end
      prev_flush = rst || branch_taken;
      prev_hold  = !rst && !branch_taken && (instr_valid === 1'b1) && decode_stall;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
  end

  initial begin
    // Back-to-back fetches with a 1-cycle memory.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("t1_req_count", 32'(req_cnt), 32'd4);
    check("t1_accept_count", 32'(acc_cnt), 32'd3);

    // Stall for five cycles after the first instruction lands.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_no_req_in_hold", 32'(req_cnt), 32'd2);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_req_after_release", 32'(req_cnt), 32'd3);
    check("t2_skid_valid", 32'(instr_valid), 32'h1);
    check("t2_skid_pc", instr_pc, 32'h4);
    check("t2_next_addr", imem_addr, 32'h8);

    // Redirect while a 3-cycle read is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_accept_count", 32'(acc_cnt), 32'd1);

    // Redirect coincides with a response while decode is stalled.
    lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_req_target", 32'(imem_req), 32'h1);
    check("t4_addr_target", imem_addr, 32'h200);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_accept_count", 32'(acc_cnt), 32'd2);

    // PC wrap at the top of the address space.
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_addr_wrap", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset while a read is pending; its response lands in the first cycle after reset.
    lat_min = 2; lat_max = 2;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("t6_rst_valid", 32'(instr_valid), 32'h0);
    check("t6_rst_pc", instr_pc, 32'h0);
    check("t6_rst_opcode", 32'(opcode), 32'h0);
    acc_cnt = 0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_stray_seen", 32'(imem_valid), 32'h1);
    check("t6_first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_accept_count", 32'(acc_cnt), 32'd1);

    // Randomized traffic: stalls, redirects, variable latency, occasional reset.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, b, s;
      logic [31:0] t;
      r = ($urandom_range(999) < 3);
      b = !r && ($urandom_range(99) < 4);
      s = ($urandom_range(99) < 40);
      t = $urandom & 32'hFFFF_FFFC;
      step(r, b, t, s);
    end
    @(posedge clk); #1;
    check("random_progress", 32'(acc_cnt > 200), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
